// File: rtl/ov_dvp_pkg.sv
// Shared types and constants for the OV7670-style DVP test-pattern transmitter.
package ov_dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VS     = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS      = 2'd0,
    PAT_RAMP      = 2'd1,
    PAT_SOLID     = 2'd2,
    PAT_SOLID_ALT = 2'd3
  } pattern_t;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_RGB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic int line_bytes(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

endpackage

// File: rtl/ov_dvp_pattern_gen.sv
// Combinational RGB565 pattern source: maps pixel coordinates and the frame's
// captured pattern settings to one 16-bit pixel.
module ov_dvp_pattern_gen
  import ov_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  pattern_t    i_pattern,
  input  logic [15:0] i_solid_rgb,
  output logic [15:0] o_pixel
);

  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_DIV = (BAR_W > 0) ? BAR_W : 1;

  logic [15:0] w_bar_idx;

  always_comb begin
    w_bar_idx = i_x / 16'(BAR_DIV);
    o_pixel   = 16'h0000;
    case (i_pattern)
      // Pixels past the eighth full bar stay black
      PAT_BARS: if (BAR_W > 0 && w_bar_idx < 16'd8) o_pixel = BAR_RGB[w_bar_idx[2:0]];
      PAT_RAMP: o_pixel = i_x + i_y;
      default:  o_pixel = i_solid_rgb;
    endcase
  end

endmodule

// File: rtl/ov_dvp_tx.sv
// DVP frame generator: VSYNC/HREF timing plus byte-serialised RGB565 patterns.
// Define OV_DVP_TX_FRAME_CNT_EN to stamp a 16-bit frame number into pixel (0,0).
//
// state     | meaning
// ST_IDLE   | waiting for enable, all outputs low
// ST_VS     | vsync pulse lines
// ST_VBP    | vertical back porch lines
// ST_ACTIVE | active lines, href high for 2*H_ACTIVE bytes per line
// ST_VFP    | vertical front porch lines, frame ends on its last byte
module ov_dvp_tx
  import ov_dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 288,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  db,
  output logic        frame_done,
  output logic        busy
`ifdef OV_DVP_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int LINE_BYTES = line_bytes(H_ACTIVE, H_BLANK);
  localparam int BW         = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int MAX_VA     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_VB     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES  = (MAX_VA > MAX_VB) ? MAX_VA : MAX_VB;
  localparam int LW         = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - 1);

  state_t      r_state;
  logic [BW-1:0] r_byte;
  logic [LW-1:0] r_line;
  pattern_t    r_pat;
  logic [15:0] r_solid;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_db;
  logic        r_frame_done;
  logic        r_busy;

  state_t        w_state_nxt;
  state_t        w_seq_next;
  logic [BW-1:0] w_byte_nxt;
  logic [LW-1:0] w_line_nxt;
  logic          w_frame_end;
  logic          w_frame_start;
  logic          w_done_nxt;
  logic          w_href_nxt;
  pattern_t      w_pat_eff;
  logic [15:0]   w_solid_eff;
  logic [15:0]   w_x;
  logic [15:0]   w_y;
  logic [15:0]   w_pat_pix;
  logic [15:0]   w_pix;

  function automatic int cnt_of(input state_t s);
    case (s)
      ST_VS:     return VSYNC_LINES;
      ST_VBP:    return V_BACK;
      ST_ACTIVE: return V_ACTIVE;
      ST_VFP:    return V_FRONT;
      default:   return 0;
    endcase
  endfunction

  // First state with a non-zero line count at or after code lo; IDLE if none
  function automatic state_t first_from(input logic [2:0] lo);
    state_t r;
    r = ST_IDLE;
    if (V_FRONT != 0 && lo <= 3'd4) r = ST_VFP;
    if (V_ACTIVE != 0 && lo <= 3'd3) r = ST_ACTIVE;
    if (V_BACK != 0 && lo <= 3'd2) r = ST_VBP;
    if (VSYNC_LINES != 0 && lo <= 3'd1) r = ST_VS;
    return r;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_byte_nxt    = r_byte;
    w_line_nxt    = r_line;
    w_frame_end   = 1'b0;
    w_frame_start = 1'b0;
    w_seq_next    = first_from(r_state + 3'd1);
    if (r_state == ST_IDLE) begin
      w_byte_nxt = '0;
      w_line_nxt = '0;
      if (enable) begin
        w_state_nxt   = first_from(3'd1);
        w_frame_start = (first_from(3'd1) != ST_IDLE);
      end
    end else if (r_byte == BYTE_LAST) begin
      w_byte_nxt = '0;
      if (int'(r_line) == cnt_of(r_state) - 1) begin
        w_line_nxt = '0;
        if (w_seq_next != ST_IDLE) begin
          w_state_nxt = w_seq_next;
        end else begin
          w_frame_end   = 1'b1;
          w_frame_start = enable;
          w_state_nxt   = enable ? first_from(3'd1) : ST_IDLE;
        end
      end else begin
        w_line_nxt = r_line + LW'(1);
      end
    end else begin
      w_byte_nxt = r_byte + BW'(1);
    end
  end

  // Outputs are registered from the next-state view so they align with the state
  always_comb begin
    w_done_nxt = (w_state_nxt != ST_IDLE) && (w_byte_nxt == BYTE_LAST) &&
                 (int'(w_line_nxt) == cnt_of(w_state_nxt) - 1) &&
                 (first_from(w_state_nxt + 3'd1) == ST_IDLE);
    w_href_nxt = (w_state_nxt == ST_ACTIVE) && (int'(w_byte_nxt) < 2 * H_ACTIVE);
    w_pat_eff   = w_frame_start ? pattern_t'(pattern_sel) : r_pat;
    w_solid_eff = w_frame_start ? solid_rgb : r_solid;
    w_x = 16'(w_byte_nxt >> 1);
    w_y = 16'(w_line_nxt);
  end

  ov_dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_gen (
    .i_x         (w_x),
    .i_y         (w_y),
    .i_pattern   (w_pat_eff),
    .i_solid_rgb (w_solid_eff),
    .o_pixel     (w_pat_pix)
  );

`ifdef OV_DVP_TX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] w_cnt_eff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_frame_cnt <= 16'h0000;
    else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  always_comb begin
    w_cnt_eff = w_frame_end ? r_frame_cnt + 16'd1 : r_frame_cnt;
    w_pix     = (w_x == 16'd0 && w_y == 16'd0) ? w_cnt_eff : w_pat_pix;
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign w_pix = w_pat_pix;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_byte       <= '0;
      r_line       <= '0;
      r_pat        <= PAT_BARS;
      r_solid      <= 16'h0000;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_db         <= 8'h00;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte       <= w_byte_nxt;
      r_line       <= w_line_nxt;
      r_vsync      <= (w_state_nxt == ST_VS);
      r_href       <= w_href_nxt;
      r_db         <= w_href_nxt ? (w_byte_nxt[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
      r_frame_done <= w_done_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_frame_start) begin
        r_pat   <= pattern_t'(pattern_sel);
        r_solid <= solid_rgb;
      end
    end
  end

  assign vsync      = r_vsync;
  assign href       = r_href;
  assign db         = r_db;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ov_dvp_tx.sv
// Self-checking bench for ov_dvp_tx with a small frame (20-byte lines, 100-cycle frames).
// Build with OV_DVP_TX_FRAME_CNT_EN to also exercise the frame-number stamp.
module tb_ov_dvp_tx;

  localparam int H  = 8;
  localparam int HB = 4;
  localparam int VA = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        vsync;
  logic        href;
  logic [7:0]  db;
  logic        frame_done;
  logic        busy;
`ifdef OV_DVP_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  ov_dvp_tx #(
    .H_ACTIVE    (H),
    .H_BLANK     (HB),
    .V_ACTIVE    (VA),
    .VSYNC_LINES (1),
    .V_BACK      (1),
    .V_FRONT     (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .vsync       (vsync),
    .href        (href),
    .db          (db),
    .frame_done  (frame_done),
    .busy        (busy)
`ifdef OV_DVP_TX_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_run = 0;
  int          n_fail = 0;
  int          model_fnum = 0;
  logic [7:0]  q_exp [$];
  logic [7:0]  mon_exp;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] model_pix(input int pat, input logic [15:0] solid,
                                            input int x, input int y, input int fnum);
    logic [15:0] p;
    int k;
    k = x * 8 / H;
    case (pat)
      0:       p = (k < 8) ? bars[k] : 16'h0000;
      1:       p = 16'(x + y);
      default: p = solid;
    endcase
`ifdef OV_DVP_TX_FRAME_CNT_EN
    if (x == 0 && y == 0) p = 16'(fnum);
`endif
    return p;
  endfunction

  task automatic push_frame(input int pat, input logic [15:0] solid);
    logic [15:0] p;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < H; x++) begin
        p = model_pix(pat, solid, x, y, model_fnum);
        q_exp.push_back(p[15:8]);
        q_exp.push_back(p[7:0]);
      end
    end
    model_fnum++;
  endtask

  // Scoreboard: every href byte is popped against the expected stream
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (href === 1'b1) begin
          n_run++;
          if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: db=%02h with no expected byte at %0t", db, $time);
          end else begin
            mon_exp = q_exp.pop_front();
            if (db !== mon_exp) begin
              n_fail++;
              $display("FAIL sb_byte: db=%02h expected %02h at %0t", db, mon_exp, $time);
            end
          end
        end else begin
          n_run++;
          if (db !== 8'h00) begin
            n_fail++;
            $display("FAIL db_idle: db=%02h expected 00 (href=%b) at %0t", db, href, $time);
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_run++;
    if ({vsync, href, db, frame_done, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %03h expected 000", {vsync, href, db, frame_done, busy});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_run++;
      if ({vsync, href, db, frame_done, busy} !== 12'h000) begin
        n_fail++;
        $display("FAIL idle_quiet: cycle %0d got %03h expected 000", i,
                 {vsync, href, db, frame_done, busy});
      end
    end
  endtask

  // Two back-to-back bar frames; enable dropped in frame 2 so it ends in IDLE
  task automatic test_bars_timing();
    int p, line, b;
    logic [3:0] exp;
    pattern_sel = 2'd0;
    push_frame(0, 16'h0000);
    push_frame(0, 16'h0000);
    enable = 1'b1;
    for (int i = 1; i <= 210; i++) begin
      @(negedge clk);
      if (i == 125) enable = 1'b0;
      p = (i - 1) % 100;
      line = p / 20;
      b = p % 20;
      if (i <= 200)
        exp = {line == 0, (line == 2 || line == 3) && b < 16, p == 99, 1'b1};
      else
        exp = 4'b0000;
      n_run++;
      if ({vsync, href, frame_done, busy} !== exp) begin
        n_fail++;
        $display("FAIL timing: cycle %0d {vsync,href,done,busy}=%b expected %b", i,
                 {vsync, href, frame_done, busy}, exp);
      end
    end
    n_run++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL bars_drain: %0d bytes left expected 0", q_exp.size());
    end
  endtask

  task automatic test_solid();
    pattern_sel = 2'd2;
    solid_rgb = 16'hA5C3;
    push_frame(2, 16'hA5C3);
    push_frame(2, 16'h1234);
    enable = 1'b1;
    for (int i = 1; i <= 205; i++) begin
      @(negedge clk);
      if (i == 50) solid_rgb = 16'h1234;
      if (i == 150) enable = 1'b0;
      n_run++;
      if (frame_done !== (i == 100 || i == 200)) begin
        n_fail++;
        $display("FAIL solid_done: cycle %0d frame_done=%b expected %b", i, frame_done,
                 (i == 100 || i == 200));
      end
    end
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL solid_stop: busy=%b expected 0", busy);
    end
    n_run++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL solid_drain: %0d bytes left expected 0", q_exp.size());
    end
  endtask

  task automatic test_reset_mid();
    int line, b;
    logic [3:0] exp;
    pattern_sel = 2'd0;
    push_frame(0, 16'h0000);
    enable = 1'b1;
    for (int i = 1; i <= 45; i++) @(negedge clk);
    n_run++;
    if (href !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_href: href=%b expected 1", href);
    end
    #1 reset_n = 1'b0;
    #1;
    n_run++;
    if ({vsync, href, db, frame_done, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got %03h expected 000", {vsync, href, db, frame_done, busy});
    end
    q_exp.delete();
    model_fnum = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_frame(0, 16'h0000);
    for (int i = 1; i <= 105; i++) begin
      @(negedge clk);
      if (i == 30) enable = 1'b0;
      line = (i - 1) / 20;
      b = (i - 1) % 20;
      if (i <= 100)
        exp = {line == 0, (line == 2 || line == 3) && b < 16, i == 100, 1'b1};
      else
        exp = 4'b0000;
      n_run++;
      if ({vsync, href, frame_done, busy} !== exp) begin
        n_fail++;
        $display("FAIL restart: cycle %0d {vsync,href,done,busy}=%b expected %b", i,
                 {vsync, href, frame_done, busy}, exp);
      end
    end
    n_run++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL restart_drain: %0d bytes left expected 0", q_exp.size());
    end
  endtask

`ifdef OV_DVP_TX_FRAME_CNT_EN
  task automatic test_ramp_stamp();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    q_exp.delete();
    model_fnum = 0;
    pattern_sel = 2'd1;
    push_frame(1, 16'h0000);
    push_frame(1, 16'h0000);
    push_frame(1, 16'h0000);
    enable = 1'b1;
    for (int i = 1; i <= 305; i++) begin
      @(negedge clk);
      if (i == 250) enable = 1'b0;
      if (i == 67) begin
        n_run++;
        if (db !== 8'h00) begin
          n_fail++;
          $display("FAIL ramp_y1x3_hi: db=%02h expected 00", db);
        end
      end
      if (i == 68) begin
        n_run++;
        if (db !== 8'h04) begin
          n_fail++;
          $display("FAIL ramp_y1x3_lo: db=%02h expected 04", db);
        end
      end
      if (i == 150 || i == 305) begin
        n_run++;
        if (frame_cnt !== ((i == 150) ? 16'd1 : 16'd3)) begin
          n_fail++;
          $display("FAIL frame_cnt: cycle %0d got %0d expected %0d", i, frame_cnt,
                   (i == 150) ? 1 : 3);
        end
      end
    end
    n_run++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL ramp_drain: %0d bytes left expected 0", q_exp.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bars_timing();
    test_solid();
    test_reset_mid();
`ifdef OV_DVP_TX_FRAME_CNT_EN
    test_ramp_stamp();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ov_dvp_tx.md
OV_DVP_TX -- requirements
Module: ov_dvp_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter H_BLANK, default 288: idle byte-cycles per line after HREF drops.
REQ-003 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 Parameters VSYNC_LINES, V_BACK, V_FRONT, defaults 3, 17, 10: line counts of the VSYNC pulse, the back porch and the front porch.
REQ-005 clk  input  1: the single clock, used as the pixel/byte clock; all logic is on its rising edge.
REQ-006 reset_n  input  1: asynchronous active-low reset.
REQ-007 enable  input  1: level signal that requests continuous frame generation.
REQ-008 pattern_sel  input  2: pattern select; 0 = colour bars, 1 = ramp, 2 = solid, 3 = solid.
REQ-009 solid_rgb  input  16: RGB565 value used by the solid pattern.
REQ-010 vsync  output  1: OV7670-style VSYNC, active high.
REQ-011 href  output  1: high while line bytes are valid.
REQ-012 db  output  8: pixel byte bus.
REQ-013 frame_done  output  1: one-cycle pulse at the end of each frame.
REQ-014 busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-015 Define LINE_BYTES = 2*H_ACTIVE + H_BLANK; every line, including blank lines, lasts exactly LINE_BYTES cycles.
REQ-016 The FSM shall have the states IDLE, VS, VBP, ACTIVE, VFP.
- IDLE -> VS on the first cycle with enable=1.
- VS lasts VSYNC_LINES lines, with vsync=1.
- VBP lasts V_BACK lines.
- ACTIVE lasts V_ACTIVE lines.
- VFP lasts V_FRONT lines.
REQ-017 In ACTIVE, href shall be 1 for the first 2*H_ACTIVE cycles of each line and 0 for the remaining H_BLANK cycles.
REQ-018 href shall be 0 in all states other than ACTIVE.
REQ-019 When href=1, each pixel shall take two cycles: high byte (R[4:0],G[5:3]) first, then low byte (G[2:0],B[4:0]).
REQ-020 db shall be 8'h00 whenever href=0.
REQ-021 All outputs shall be registered, and vsync, href and db shall change on the same edge.
REQ-022 pattern_sel and solid_rgb shall be captured at IDLE->VS and at VFP->VS; they shall be held constant for the whole frame, and mid-frame changes shall be ignored.
REQ-023 Colour-bar pattern: 8 equal bars of H_ACTIVE/8 pixels each; bar k = x*8/H_ACTIVE.
- Bar values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Any remainder pixels shall use black.
REQ-024 Ramp pattern: pixel = x[15:0] + y[15:0], modulo 2^16, where x and y are 0-based pixel and line indices.
REQ-025 Solid pattern: every pixel = the captured solid_rgb.
REQ-026 frame_done shall be 1 during the final cycle of the last VFP line.
REQ-027 On that same final cycle, the FSM shall go to VS if enable=1, otherwise to IDLE.
REQ-028 Deasserting enable mid-frame shall not truncate the frame; the current frame completes.
REQ-029 Any line count parameter equal to 0 shall cause that state to be skipped with zero cycles.
REQ-030 Byte, line and pixel counters shall be sized with $clog2 of their maximum value and shall wrap to 0 at line and frame boundaries.

Reset
REQ-031 While reset_n=0, the block shall hold state=IDLE, vsync=0, href=0, db=0, frame_done=0, busy=0, and all counters at 0.
REQ-032 Reset asserted mid-frame shall force these values asynchronously.
REQ-033 After release, no output shall change until enable=1 is sampled.

Configuration
REQ-034 The macro OV_DVP_TX_FRAME_CNT_EN shall control a frame-number stamp.
- Defined: a 16-bit frame counter (reset 0, +1 per frame_done, wraps) replaces pixel (0,0) of each frame, high byte first, for every pattern.
- Defined: the counter is exposed as output frame_cnt [15:0].
- Undefined: no counter, no frame_cnt port, and pixel (0,0) follows the pattern.

Structure
REQ-035 Package ov_dvp_pkg shall hold:
- the FSM state enum;
- the pattern_sel enum;
- the eight RGB565 bar constants;
- a function returning LINE_BYTES.
REQ-036 A combinational sub-module ov_dvp_pattern_gen shall map (x, y, pattern, solid_rgb) to a 16-bit pixel.
REQ-037 Byte selection and registering shall stay in ov_dvp_tx.

Verification
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, giving LINE_BYTES=20 and a frame of 100 cycles.
REQ-038 Colour bars: enable=1, pattern_sel=0 -> each active line shall have 16 href cycles with bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00, then 4 cycles of href=0, db=00.
REQ-039 Timing: vsync shall be high for exactly 20 cycles starting 1 cycle after enable, and href shall rise 20 cycles after vsync falls.
REQ-040 Timing: frame_done shall pulse at cycle 100 of each frame, and the next vsync shall rise on the following cycle.
REQ-041 Solid: pattern_sel=2, solid_rgb=16'hA5C3 -> bytes shall alternate A5, C3.
REQ-042 Solid: changing solid_rgb mid-frame to 16'h1234 shall not affect the current frame; the next frame shall show 12, 34.
REQ-043 Stop: enable dropped in line 2 -> the frame shall complete, frame_done shall pulse, busy shall fall, and the block shall remain in IDLE.
REQ-044 Reset: reset_n pulsed low mid-ACTIVE -> vsync, href and db shall be 0 with no clock edge; after release with enable=1, a full frame shall restart from VS.
REQ-045 Ramp with OV_DVP_TX_FRAME_CNT_EN defined, pattern_sel=1 -> first two bytes shall be 00 00, 00 01, 00 02 in frames 0, 1 and 2, and line 1 pixel 3 shall be 00 04.
